// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding imem handshake
// and presents a one-entry IF/ID register. Optional feature macro: FETCH_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | post-reset bubble, request next cycle
// REQ   | request pc to imem, wait for grant
// WAIT  | granted, wait for response
// HOLD  | response parked in pending register, IF/ID still occupied
// DROP  | flushed while a request was in flight, swallow its response
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] pend_inst;
  logic        adel_q;
  logic        out_free;
  logic        misalign;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = (pc_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign out_free  = !id_valid || id_ready;
  assign imem_req  = (state == S_REQ) && !misalign;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign id_adel   = adel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_inst <= '0;
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_inst   <= '0;
      adel_q    <= 1'b0;
    end else if (flush) begin
      // flush beats everything, including a same-cycle consume or load
      id_valid <= 1'b0;
      pc_q     <= flush_pc;
      case (state)
        S_REQ:   state <= (imem_req && imem_gnt) ? S_DROP : S_REQ;
        S_WAIT:  state <= imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state <= imem_rvalid ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      if (id_valid && id_ready)
        id_valid <= 1'b0;
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (misalign) begin
            // misaligned fetch completes locally without touching imem
            if (out_free) begin
              id_inst  <= NOP_INST;
              id_pc    <= pc_q;
              adel_q   <= 1'b1;
              id_valid <= 1'b1;
              pc_q     <= npc;
            end
          end else if (imem_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (out_free) begin
              id_inst  <= imem_rdata;
              id_pc    <= pc_q;
              adel_q   <= 1'b0;
              id_valid <= 1'b1;
              pc_q     <= npc;
              state    <= S_REQ;
            end else begin
              pend_inst <= imem_rdata;
              state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            id_inst  <= pend_inst;
            id_pc    <= pc_q;
            adel_q   <= 1'b0;
            id_valid <= 1'b1;
            pc_q     <= npc;
            state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid)
            state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that owns the architectural fetch PC register.
- Feeds the current PC to the next-PC unit and to instruction memory over a request/grant/response handshake.
- Loads the PC from the next-PC unit's result each time an instruction is handed to decode.
- Presents a one-entry IF/ID output with valid/ready backpressure and supports flush/redirect with in-flight response dropping.

Parameters:
RESET_PC, 32'hBFC00000, PC value loaded on reset
NOP_INST, 32'h00000000, instruction word presented for a faulted fetch

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
npc  input  32  next PC from next-PC unit (computed from pc output)
flush  input  1  discard everything younger than decode, restart at flush_pc
flush_pc  input  32  redirect target, valid when flush=1
pc  output  32  current fetch PC (to next-PC unit)
imem_req  output  1  fetch request, combinational from state
imem_addr  output  32  fetch address (= pc)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid; cannot be back-pressured
imem_rdata  input  32  fetched instruction word
id_valid  output  1  IF/ID entry valid
id_ready  input  1  decode consumes entry when id_valid && id_ready
id_pc  output  32  PC of the presented instruction
id_inst  output  32  presented instruction
id_adel  output  1  fetch address error flag for the presented instruction

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=IDLE, id_valid=0, id_pc=0, id_inst=0, id_adel=0, pending buffer empty.
  - imem_req=0 while in IDLE.
- States:
  - IDLE: always go to REQ next cycle.
  - REQ: imem_req=1, imem_addr=pc. imem_gnt=1 -> WAIT. Single outstanding request only.
  - WAIT: on imem_rvalid:
    - If output free (id_valid=0 or id_ready=1): id_inst<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=npc, -> REQ.
    - Else: capture imem_rdata into pending register, -> HOLD.
  - HOLD: imem_req=0. On id_ready: id_inst<=pending, id_pc<=pc, id_valid stays 1, pc<=npc, -> REQ.
  - DROP: imem_req=0. On imem_rvalid: discard data, -> REQ.
- Advance rules:
  - PC advances only when an instruction is loaded into the output register, so npc is sampled at that edge only.
  - Best-case throughput: one instruction per 2 cycles with 0-latency memory (REQ, WAIT).
  - Consume without reload: id_valid<=0.
- Flush (highest priority, overrides all above):
  - id_valid<=0, pc<=flush_pc, pending discarded.
  - IDLE -> REQ.
  - REQ: -> DROP if imem_gnt in the same cycle (old address granted), else stays REQ.
  - WAIT: -> REQ if imem_rvalid in the same cycle (data discarded), else -> DROP.
  - HOLD -> REQ.
  - DROP: stays DROP unless imem_rvalid, then -> REQ.
- Simultaneous events:
  - id_ready + new load in the same cycle: output overwritten, id_valid stays 1.
  - flush + id_ready: flush wins, nothing loaded.
- Reset mid-transaction:
  - Internal state cleared; a late imem_rvalid arriving in IDLE/REQ is ignored.
  - The memory side guarantees no response after reset.
- Arithmetic: no arithmetic in this block; PC increment is done by the next-PC unit. pc wraps naturally through npc.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: in REQ, if pc[1:0]!=0, imem_req stays 0 and the fetch completes locally in the same cycle.
  - If output free: id_inst<=NOP_INST, id_adel<=1, id_pc<=pc, id_valid<=1, pc<=npc.
  - Otherwise wait in REQ until free.
  - id_adel=0 for normal fetches.
- Undefined: no check; misaligned pc issued to memory unchanged; id_adel tied 0.

Test Plan:
- Reset then fetch: rst 1 cycle; memory gnt immediate, rvalid next cycle, id_ready=1, npc=pc+4 model.
  - Expect imem_addr BFC00000, BFC00004, BFC00008.
  - Expect id_pc following one per 2 cycles, id_valid=1 from cycle 4.
- Backpressure: id_ready=0 for 5 cycles while response 0x24020001 at BFC00004 arrives.
  - Expect HOLD, imem_req=0, id_pc/id_inst stable.
  - On id_ready=1, new entry BFC00004/0x24020001 next cycle; no lost or duplicated instruction.
- Flush in WAIT: flush=1, flush_pc=0x80000100 before rvalid.
  - Expect DROP, late response discarded, next imem_addr=0x80000100, id_valid=0 until its data.
- Flush coincident with gnt in REQ and with rvalid in WAIT.
  - Expect DROP and direct REQ respectively.
  - No stale instruction ever reaches id_inst.
- Slow memory: gnt delayed 3 cycles, rvalid delayed 4 cycles.
  - Expect imem_req held high with constant imem_addr until gnt; single outstanding request.
- FETCH_ALIGN_CHECK_EN defined, flush_pc=0x80000102.
  - Expect no imem_req, id_adel=1, id_inst=0, id_pc=0x80000102.
  - With macro undefined, expect imem_addr=0x80000102 and id_adel=0.
